serial_subtractor_ctrl: RTL and testbench

Bit-serial subtraction controller that sequences a single external `full_subtractor` bit cell over WIDTH cycles to compute a WIDTH-bit difference with borrow. It latches operands on a start request and feeds the cell one bit per cycle, LSB first. It recirculates the cell's borrow output into its `bin`, assembles the difference word and signals completion. It sits between a requesting datapath and one `full_subtractor` instance, which it owns exclusively.

---
 rtl/serial_subtractor_ctrl.sv | 115 +++++++++++
 tb/tb_serial_subtractor_ctrl.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial subtraction controller.
// Drives one external full_subtractor cell for WIDTH cycles, LSB first, recirculating the
// cell's borrow and assembling the difference word. Results are held until the next completion.
module serial_subtractor_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a_in,
  input  logic [WIDTH-1:0] i_b_in,
  input  logic             i_bin_in,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_diff_out,
  output logic             o_borrow_out,
  output logic             o_cell_a,
  output logic             o_cell_b,
  output logic             o_cell_bin,
  input  logic             i_cell_diff,
  input  logic             i_cell_borrow
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } state_e;

  state_e          r_state;
  state_e          w_state_next;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_d_sh;
  logic            r_brw;
  logic [CntW-1:0] r_cnt;
  logic [WIDTH-1:0] w_d_next;
  logic            w_last;

  // New diff bit enters at the MSB so that after WIDTH shifts bit 0 sits at the LSB.
  if (WIDTH == 1) begin : g_d_one
    assign w_d_next = i_cell_diff;
  end else begin : g_d_many
    assign w_d_next = {i_cell_diff, r_d_sh[WIDTH-1:1]};
  end

  assign w_last = (r_cnt == LastCnt);

  // State register with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; start is only honoured in idle.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle:  if (i_start) w_state_next = StShift;
      StShift: if (w_last) w_state_next = StDone;
      StDone:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  // Operand shifters, borrow recirculation, counter and held result registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_a_sh       <= '0;
      r_b_sh       <= '0;
      r_d_sh       <= '0;
      r_brw        <= 1'b0;
      r_cnt        <= '0;
      o_diff_out   <= '0;
      o_borrow_out <= 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          if (i_start) begin
            r_a_sh <= i_a_in;
            r_b_sh <= i_b_in;
            r_brw  <= i_bin_in;
            r_cnt  <= '0;
          end
        end
        StShift: begin
          r_d_sh <= w_d_next;
          r_brw  <= i_cell_borrow;
          r_a_sh <= r_a_sh >> 1;
          r_b_sh <= r_b_sh >> 1;
          r_cnt  <= r_cnt + 1'b1;
          if (w_last) begin
            o_diff_out   <= w_d_next;
            o_borrow_out <= i_cell_borrow;
          end
        end
        default: ;
      endcase
    end
  end

  // Cell drive and status are decoded purely from registers.
  assign o_cell_a   = r_a_sh[0];
  assign o_cell_b   = r_b_sh[0];
  assign o_cell_bin = r_brw;
  assign o_busy     = (r_state == StShift);
  assign o_done     = (r_state == StDone);

endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// Self-checking bench for serial_subtractor_ctrl: an 8-bit and a 1-bit instance, each wired to a
// behavioural full subtractor cell, checked against plain-arithmetic expectations.
module tb_serial_subtractor_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // 8-bit instance
  logic       start, bin_in, busy, done, borrow_out, cell_a, cell_b, cell_bin;
  logic       cell_diff, cell_borrow;
  logic [7:0] a_in, b_in, diff_out;

  // 1-bit instance
  logic w1_start, w1_a, w1_b, w1_bin, w1_busy, w1_done, w1_diff, w1_borrow;
  logic w1_ca, w1_cb, w1_cbin, w1_cdiff, w1_cborrow;

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] hold_d = 8'h00;
  logic       hold_b = 1'b0;

  assign cell_diff   = cell_a ^ cell_b ^ cell_bin;
  assign cell_borrow = (~cell_a & cell_b) | (~cell_a & cell_bin) | (cell_b & cell_bin);
  assign w1_cdiff    = w1_ca ^ w1_cb ^ w1_cbin;
  assign w1_cborrow  = (~w1_ca & w1_cb) | (~w1_ca & w1_cbin) | (w1_cb & w1_cbin);

  serial_subtractor_ctrl #(.WIDTH(8)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_a_in(a_in), .i_b_in(b_in),
    .i_bin_in(bin_in), .o_busy(busy), .o_done(done), .o_diff_out(diff_out),
    .o_borrow_out(borrow_out), .o_cell_a(cell_a), .o_cell_b(cell_b), .o_cell_bin(cell_bin),
    .i_cell_diff(cell_diff), .i_cell_borrow(cell_borrow)
  );

  serial_subtractor_ctrl #(.WIDTH(1)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_start(w1_start), .i_a_in(w1_a), .i_b_in(w1_b),
    .i_bin_in(w1_bin), .o_busy(w1_busy), .o_done(w1_done), .o_diff_out(w1_diff),
    .o_borrow_out(w1_borrow), .o_cell_a(w1_ca), .o_cell_b(w1_cb), .o_cell_bin(w1_cbin),
    .i_cell_diff(w1_cdiff), .i_cell_borrow(w1_cborrow)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Reference: (a - b - bin) mod 256, borrow iff a < b + bin.
  function automatic logic [8:0] ref_sub(input int a, input int b, input int bin);
    int v;
    v = a - b - bin;
    return {logic'(a < b + bin), v[7:0]};
  endfunction

  // Full operation with start pulsed for one cycle; checks every cycle through the return to idle.
  task automatic do_op8(input logic [7:0] a, input logic [7:0] b, input logic bin,
                        input string name);
    logic [8:0] r;
    logic       eb_in;
    int         am, bm;
    r = ref_sub(int'(a), int'(b), int'(bin));
    a_in = a; b_in = b; bin_in = bin; start = 1'b1;
    cyc();
    start = 1'b0;
    a_in = 8'($urandom); b_in = 8'($urandom); bin_in = 1'($urandom);
    for (int k = 0; k < 8; k++) begin
      am = int'(a) & ((1 << k) - 1);
      bm = int'(b) & ((1 << k) - 1);
      eb_in = (am < bm + int'(bin));
      n_vec++;
      if (busy !== 1'b1 || done !== 1'b0 || diff_out !== hold_d || borrow_out !== hold_b) begin
        n_err++;
        $display("FAIL %s shift%0d status: busy=%b done=%b diff=%h brw=%b want 1 0 %h %b",
                 name, k, busy, done, diff_out, borrow_out, hold_d, hold_b);
      end
      n_vec++;
      if (cell_a !== a[k] || cell_b !== b[k] || cell_bin !== eb_in) begin
        n_err++;
        $display("FAIL %s cell%0d: a=%b b=%b bin=%b want %b %b %b",
                 name, k, cell_a, cell_b, cell_bin, a[k], b[k], eb_in);
      end
      cyc();
    end
    hold_d = r[7:0];
    hold_b = r[8];
    n_vec++;
    if (done !== 1'b1 || busy !== 1'b0 || diff_out !== hold_d || borrow_out !== hold_b) begin
      n_err++;
      $display("FAIL %s done: done=%b busy=%b diff=%h brw=%b want 1 0 %h %b",
               name, done, busy, diff_out, borrow_out, hold_d, hold_b);
    end
    cyc();
    n_vec++;
    if (done !== 1'b0 || busy !== 1'b0 || diff_out !== hold_d || borrow_out !== hold_b) begin
      n_err++;
      $display("FAIL %s idle: done=%b busy=%b diff=%h brw=%b want 0 0 %h %b",
               name, done, busy, diff_out, borrow_out, hold_d, hold_b);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; a_in = 8'h33; b_in = 8'h11; bin_in = 1'b0;
    w1_start = 1'b0; w1_a = 1'b0; w1_b = 1'b0; w1_bin = 1'b0;
    for (int i = 0; i < 2; i++) begin
      cyc();
      n_vec++;
      if ({busy, done, diff_out, borrow_out, cell_a, cell_b, cell_bin} !== 13'd0) begin
        n_err++;
        $display("FAIL reset%0d: busy=%b done=%b diff=%h brw=%b cells=%b%b%b want all 0",
                 i, busy, done, diff_out, borrow_out, cell_a, cell_b, cell_bin);
      end
    end
    rst = 1'b0;
    hold_d = 8'h00; hold_b = 1'b0;
    do_op8(8'h33, 8'h11, 1'b0, "reset_first_accept");
  endtask

  task automatic test_basic();
    do_op8(8'h5A, 8'h3C, 1'b0, "basic");
  endtask

  task automatic test_wrap();
    do_op8(8'h00, 8'h01, 1'b0, "wrap_0_1");
    do_op8(8'hFF, 8'hFF, 1'b1, "wrap_ff_ff_1");
  endtask

  task automatic test_ignore_busy();
    a_in = 8'h5A; b_in = 8'h3C; bin_in = 1'b0; start = 1'b1;
    cyc();
    start = 1'b0; a_in = 8'h00; b_in = 8'hFF;
    for (int k = 0; k < 8; k++) begin
      start = (k == 3);
      cyc();
    end
    n_vec++;
    if (done !== 1'b1 || diff_out !== 8'h1E || borrow_out !== 1'b0) begin
      n_err++;
      $display("FAIL ignore_result: done=%b diff=%h brw=%b want 1 1e 0",
               done, diff_out, borrow_out);
    end
    start = 1'b1;  // sampled in DONE: must be ignored
    cyc();
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      n_vec++;
      if (busy !== 1'b0 || done !== 1'b0) begin
        n_err++;
        $display("FAIL ignore_no_restart%0d: busy=%b done=%b want 0 0", k, busy, done);
      end
      cyc();
    end
    hold_d = 8'h1E; hold_b = 1'b0;
  endtask

  task automatic test_abort();
    a_in = 8'h5A; b_in = 8'h3C; bin_in = 1'b0; start = 1'b1;
    cyc();
    start = 1'b0;
    for (int k = 0; k < 3; k++) cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    n_vec++;
    if ({busy, done, diff_out, borrow_out, cell_a, cell_b, cell_bin} !== 13'd0) begin
      n_err++;
      $display("FAIL abort_clear: busy=%b done=%b diff=%h brw=%b cells=%b%b%b want all 0",
               busy, done, diff_out, borrow_out, cell_a, cell_b, cell_bin);
    end
    for (int k = 0; k < 10; k++) begin
      n_vec++;
      if (busy !== 1'b0 || done !== 1'b0) begin
        n_err++;
        $display("FAIL abort_quiet%0d: busy=%b done=%b want 0 0", k, busy, done);
      end
      cyc();
    end
    hold_d = 8'h00; hold_b = 1'b0;
    do_op8(8'h10, 8'h01, 1'b0, "after_abort");
  endtask

  task automatic test_random();
    for (int i = 0; i < 24; i++) begin
      do_op8(8'($urandom), 8'($urandom), 1'($urandom), "random");
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) cyc();
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] a1, b1, a2, b2;
    logic [8:0] r1, r2;
    a1 = 8'($urandom); b1 = 8'($urandom); a2 = 8'($urandom); b2 = 8'($urandom);
    r1 = ref_sub(int'(a1), int'(b1), 1);
    r2 = ref_sub(int'(a2), int'(b2), 0);
    a_in = a1; b_in = b1; bin_in = 1'b1; start = 1'b1;
    cyc();
    a_in = a2; b_in = b2; bin_in = 1'b0;
    for (int k = 0; k < 8; k++) cyc();
    n_vec++;
    if (done !== 1'b1 || {borrow_out, diff_out} !== r1) begin
      n_err++;
      $display("FAIL b2b_first: done=%b result=%h want 1 %h", done, {borrow_out, diff_out}, r1);
    end
    cyc();
    n_vec++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_idle_gap: busy=%b done=%b want 0 0", busy, done);
    end
    cyc();
    start = 1'b0;
    n_vec++;
    if (busy !== 1'b1 || {borrow_out, diff_out} !== r1) begin
      n_err++;
      $display("FAIL b2b_reaccept: busy=%b result=%h want 1 %h", busy, {borrow_out, diff_out}, r1);
    end
    for (int k = 0; k < 8; k++) cyc();
    n_vec++;
    if (done !== 1'b1 || {borrow_out, diff_out} !== r2) begin
      n_err++;
      $display("FAIL b2b_second: done=%b result=%h want 1 %h", done, {borrow_out, diff_out}, r2);
    end
    cyc();
    hold_d = r2[7:0]; hold_b = r2[8];
  endtask

  task automatic test_width1();
    logic ed, eb;
    for (int i = 0; i < 8; i++) begin
      w1_a = 1'(i >> 2); w1_b = 1'(i >> 1); w1_bin = 1'(i);
      ed = 1'((int'(w1_a) - int'(w1_b) - int'(w1_bin)) & 1);
      eb = (int'(w1_a) < int'(w1_b) + int'(w1_bin));
      w1_start = 1'b1;
      cyc();
      w1_start = 1'b0;
      n_vec++;
      if (w1_busy !== 1'b1 || w1_done !== 1'b0) begin
        n_err++;
        $display("FAIL w1_shift%0d: busy=%b done=%b want 1 0", i, w1_busy, w1_done);
      end
      cyc();
      n_vec++;
      if (w1_done !== 1'b1 || w1_busy !== 1'b0 || w1_diff !== ed || w1_borrow !== eb) begin
        n_err++;
        $display("FAIL w1_done%0d: done=%b busy=%b diff=%b brw=%b want 1 0 %b %b",
                 i, w1_done, w1_busy, w1_diff, w1_borrow, ed, eb);
      end
      cyc();
      n_vec++;
      if (w1_done !== 1'b0) begin
        n_err++;
        $display("FAIL w1_pulse%0d: done=%b want 0", i, w1_done);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_ignore_busy();
    test_abort();
    test_random();
    test_back_to_back();
    test_width1();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
